seq_addsub: RTL and testbench

Multi-cycle, parametrised adder/subtractor for the ALU datapath. It processes operands CHUNK bits per clock with a registered carry chain, trading latency for a short critical path. Flag semantics are the CPU's existing add/sub semantics. Adds over the single-cycle adder: generic width, saturation mode, carry-out, and a valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/chunk_adder.sv | 19 +
 rtl/seq_addsub.sv | 172 +++++++++++++++++
 tb/tb_seq_addsub.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding for the sequential datapath,
// operation and signedness encodings, and a helper for counter sizing.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // ctrl encodings
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // sign encodings
  localparam logic SIGN_UNSIGNED = 1'b0;
  localparam logic SIGN_SIGNED   = 1'b1;

  // Width of a counter that indexes n chunks; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
// Ports:
//   a, b  : CHUNK-bit addends
//   cin   : carry in
//   sum   : CHUNK-bit sum
//   cout  : carry out of the slice
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor. Operands are added CHUNK bits per clock
// through one shared chunk_adder with a registered carry, so the critical
// path is a CHUNK-bit add instead of a WIDTH-bit add. Flags and optional
// saturation are computed on the last RUN edge.
// WIDTH must be a multiple of CHUNK.
// Ports:
//   clk, rst             : clock (rising edge), async active-high reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   a, b                 : WIDTH-bit operands
//   ctrl                 : 0 = add, 1 = sub
//   sign                 : 1 = signed, 0 = unsigned flag semantics
//   sat                  : 1 = saturate result on overflow
//   out_valid / out_ready: result handshake
//   result               : WIDTH-bit sum/difference (held until next finalisation)
//   zero, negative, over, carry : result flags
module seq_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  input  logic             sign,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             over,
  output logic             carry
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             ctrl_reg, sign_reg, sat_reg, carry_reg;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
  logic             chunk_cout;
  logic             accept, last;

  logic [WIDTH-1:0] raw, fin_result;
  logic             ovf_signed, fin_over, fin_negative;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == RUN) && (idx == LAST_IDX);

  // ------------------------------------------------------------ datapath
  assign chunk_a = a_reg[idx*CHUNK +: CHUNK];
  assign chunk_b = b_reg[idx*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a   (chunk_a),
    .b   (chunk_b),
    .cin (carry_reg),
    .sum (chunk_sum),
    .cout(chunk_cout)
  );

  // Full sum including the chunk being produced this cycle; on the last RUN
  // cycle this is the complete raw result used for finalisation.
  always_comb begin
    raw = sum_reg;
    raw[idx*CHUNK +: CHUNK] = chunk_sum;
  end

  // b_reg already holds ~b for subtraction, so the same-sign test on a and
  // b_reg is the overflow test for a + (~b + 1).
  assign ovf_signed = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                      (raw[WIDTH-1] != a_reg[WIDTH-1]);

  always_comb begin
    if (sign_reg == SIGN_SIGNED) fin_over = ovf_signed;
    else if (ctrl_reg == OP_SUB) fin_over = ~chunk_cout;  // borrow
    else                         fin_over = chunk_cout;

    // Signed: the true sign of the mathematical result, even on overflow.
    if (sign_reg == SIGN_UNSIGNED) fin_negative = ctrl_reg & fin_over;
    else                           fin_negative = raw[WIDTH-1] ^ fin_over;

    fin_result = raw;
    if (sat_reg && fin_over) begin
      if (sign_reg == SIGN_SIGNED) begin
        // Overflow direction follows a's sign (both operands share it).
        fin_result = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        fin_result = (ctrl_reg == OP_SUB) ? '0 : '1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      ctrl_reg  <= 1'b0;
      sign_reg  <= 1'b0;
      sat_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      over      <= 1'b0;
      carry     <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= (ctrl == OP_ADD) ? b : ~b;
      ctrl_reg  <= ctrl;
      sign_reg  <= sign;
      sat_reg   <= sat;
      carry_reg <= ctrl;  // +1 of two's-complement negation for sub
      idx       <= '0;
    end else if (state == RUN) begin
      sum_reg   <= raw;
      carry_reg <= chunk_cout;
      idx       <= idx + IDX_W'(1);
      if (last) begin
        result   <= fin_result;
        zero     <= (fin_result == '0);
        negative <= fin_negative;
        over     <= fin_over;
        carry    <= chunk_cout;
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub. Two instances: WIDTH=32/CHUNK=8 (lane 0)
// and WIDTH=16/CHUNK=16 (lane 1). A single compare process checks handshake,
// latency, result and flags every cycle against an arithmetic model.
module tb_seq_addsub;

  typedef struct packed {
    logic [63:0] res;
    logic        z;
    logic        n;
    logic        o;
    logic        c;
  } exp_t;

  logic clk;
  logic rst;
  logic in_valid [2];
  logic in_ready [2];
  logic ctrl [2];
  logic sign [2];
  logic sat [2];
  logic out_valid [2];
  logic out_ready [2];
  logic zero [2];
  logic neg [2];
  logic over [2];
  logic carry [2];
  logic [31:0] a0, b0, res0;
  logic [15:0] a1, b1, res1;

  int W_L [2] = '{32, 16};
  int N_L [2] = '{4, 1};

  int passes = 0;
  int total  = 0;
  int cyc    = 0;

  seq_addsub #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a0), .b(b0), .ctrl(ctrl[0]), .sign(sign[0]), .sat(sat[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(res0),
    .zero(zero[0]), .negative(neg[0]), .over(over[0]), .carry(carry[0])
  );

  seq_addsub #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a1), .b(b1), .ctrl(ctrl[1]), .sign(sign[1]), .sat(sat[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(res1),
    .zero(zero[1]), .negative(neg[1]), .over(over[1]), .carry(carry[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] want);
    total++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic s, input logic t);
    longint m, maxp, minn, ua, ub, sa, sb, tt;
    logic o, n, cy;
    exp_t e;
    m    = (longint'(1) << w) - 1;
    maxp = (longint'(1) << (w - 1)) - 1;
    minn = -(longint'(1) << (w - 1));
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    sa   = (ua > maxp) ? ua - (longint'(1) << w) : ua;
    sb   = (ub > maxp) ? ub - (longint'(1) << w) : ub;
    if (s) begin
      tt = c ? sa - sb : sa + sb;
      o  = (tt > maxp) || (tt < minn);
      n  = (tt < 0);
    end else begin
      o = c ? (ua < ub) : (ua + ub > m);
      n = c & o;
    end
    cy    = c ? (ua >= ub) : (ua + ub > m);
    e.res = 64'((c ? ua - ub : ua + ub) & m);
    if (t && o) begin
      if (s) e.res = (sa < 0) ? 64'(minn & m) : 64'(maxp);
      else   e.res = c ? 64'(0) : 64'(m);
    end
    e.z = (e.res == 64'(0));
    e.n = n;
    e.o = o;
    e.c = cy;
    return e;
  endfunction

  function automatic exp_t dut_out(input int l);
    if (l == 0) return {32'b0, res0, zero[0], neg[0], over[0], carry[0]};
    else        return {48'b0, res1, zero[1], neg[1], over[1], carry[1]};
  endfunction

  // ------------------------------------------------------ compare process
  exp_t expv [2];
  exp_t held [2];
  logic pending [2];
  logic seen [2];
  int   acc [2];

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      exp_t got;
      got = dut_out(l);
      if (rst) begin
        pending[l] = 1'b0;
        held[l]    = '0;
        check($sformatf("reset_handshake_l%0d", l), 68'({in_ready[l], out_valid[l]}), 68'(2'b10));
        check($sformatf("reset_outputs_l%0d", l), got, '0);
      end else begin
        check($sformatf("in_ready_l%0d", l), 68'(in_ready[l]), 68'(!pending[l]));
        if (out_valid[l]) begin
          if (!pending[l]) begin
            check($sformatf("spurious_out_valid_l%0d", l), 68'(1), 68'(0));
          end else begin
            if (!seen[l]) begin
              check($sformatf("latency_l%0d", l), 68'(cyc - acc[l]), 68'(N_L[l] + 1));
              seen[l] = 1'b1;
            end
            check($sformatf("result_l%0d", l), got, expv[l]);
            if (out_ready[l]) begin
              pending[l] = 1'b0;
              held[l]    = expv[l];
            end
          end
        end else begin
          check($sformatf("held_l%0d", l), got, held[l]);
          if (pending[l] && (cyc - acc[l] > N_L[l] + 1)) begin
            check($sformatf("out_valid_timeout_l%0d", l), 68'(cyc - acc[l]), 68'(N_L[l] + 1));
            pending[l] = 1'b0;
          end
        end
        if (in_valid[l] && in_ready[l]) begin
          expv[l]    = model(W_L[l], (l == 0) ? 64'(a0) : 64'(a1), (l == 0) ? 64'(b0) : 64'(b1),
                             ctrl[l], sign[l], sat[l]);
          pending[l] = 1'b1;
          seen[l]    = 1'b0;
          acc[l]     = cyc;
        end
      end
    end
  end

  // -------------------------------------------------------------- drivers
  task automatic set_in(input int l, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic t, input logic v);
    if (l == 0) begin
      a0 = a;
      b0 = b;
    end else begin
      a1 = a[15:0];
      b1 = b[15:0];
    end
    ctrl[l]     = c;
    sign[l]     = s;
    sat[l]      = t;
    in_valid[l] = v;
  endtask

  // Returns at the negedge where the operation is accepted.
  task automatic wait_accept(input int l);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready[l] && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check("accept_timeout", 68'(k), 68'(0));
  endtask

  task automatic wait_out(input int l);
    int k;
    k = 0;
    while (!out_valid[l] && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check("wait_out_timeout", 68'(k), 68'(0));
  endtask

  task automatic pop_out(input int l, input int bp);
    repeat (bp) @(posedge clk);
    @(posedge clk);
    #1 out_ready[l] = 1'b1;
    @(posedge clk);
    #1 out_ready[l] = 1'b0;
  endtask

  // Mode and operand inputs are scrambled after acceptance; they must be ignored.
  task automatic run_op(input int l, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic t, input int bp);
    @(posedge clk);
    #1 set_in(l, a, b, c, s, t, 1'b1);
    wait_accept(l);
    @(posedge clk);
    #1 set_in(l, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    wait_out(l);
    pop_out(l, bp);
  endtask

  task automatic expect_out(input string name, input int l, input logic [63:0] res,
                            input logic z, input logic n, input logic o, input logic c);
    check(name, dut_out(l), {res, z, n, o, c});
  endtask

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'(1) << (w - 1);
      3:       return (32'(1) << (w - 1)) - 32'(1);
      default: return $urandom;
    endcase
  endfunction

  // ------------------------------------------------------------- stimulus
  initial begin
    int l;
    logic [31:0] ra, rb;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_in(i, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      out_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Model pinned against hand-computed values.
    check("model_uadd_wrap", model(32, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0),
          {64'h0, 1'b1, 1'b0, 1'b1, 1'b1});
    check("model_usub_sat", model(32, 64'h3, 64'h5, 1'b1, 1'b0, 1'b1),
          {64'h0, 1'b1, 1'b1, 1'b1, 1'b0});
    check("model_ssub16", model(16, 64'h8000, 64'h1, 1'b1, 1'b1, 1'b0),
          {64'h7FFF, 1'b0, 1'b1, 1'b1, 1'b1});

    // Unsigned add wrap.
    run_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 0);
    expect_out("uadd_wrap", 0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Backpressure: second op held on in_valid through RUN/DONE, accepted after pop.
    @(posedge clk);
    #1 set_in(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_accept(0);
    @(posedge clk);
    #1 set_in(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_out(0);
    repeat (2) @(posedge clk);
    #1 out_ready[0] = 1'b1;
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    expect_out("sadd_ovf", 0, 64'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("in_ready_after_pop", 68'(in_ready[0]), 68'(1));
    @(posedge clk);
    #1 set_in(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_out(0);
    pop_out(0, 0);
    expect_out("sadd_sat", 0, 64'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);

    // Subtraction 3 - 5 in each mode.
    run_op(0, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0, 1);
    expect_out("usub", 0, 64'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op(0, 32'd3, 32'd5, 1'b1, 1'b0, 1'b1, 0);
    expect_out("usub_sat", 0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_op(0, 32'd3, 32'd5, 1'b1, 1'b1, 1'b0, 2);
    expect_out("ssub", 0, 64'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset during RUN cycle 2 discards the operation.
    @(posedge clk);
    #1 set_in(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_accept(0);
    @(posedge clk);
    #1 set_in(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_op(0, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0, 0);
    expect_out("add_after_reset", 0, 64'd30, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-chunk instance.
    run_op(1, 32'h8000, 32'h1, 1'b1, 1'b1, 1'b0, 0);
    expect_out("ssub16", 1, 64'h7FFF, 1'b0, 1'b1, 1'b1, 1'b1);

    // Randomized operations on both instances.
    for (int i = 0; i < 80; i++) begin
      l  = $urandom_range(0, 1);
      ra = pick(W_L[l]);
      rb = pick(W_L[l]);
      run_op(l, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
